// File: rtl/sd_ring_demux.sv
// Receive-side ring demultiplexer: routes ring packets to the SD data path
// (memory read responses) or the SD register block. It discards packets of
// unknown class and malformed packets, and counts them in a saturating counter.
module sd_ring_demux #(
  parameter int unsigned D_LEN = 9,
  parameter int unsigned R_LEN = 2,
  parameter int unsigned ERR_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             I_STB,
  input  logic             I_SOF,
  input  logic [71:0]      I_DATA,
  output logic             I_ACK,
  output logic             O_D_STB,
  output logic             O_D_SOF,
  output logic [71:0]      O_D_DATA,
  input  logic             O_D_ACK,
  output logic             O_R_STB,
  output logic             O_R_SOF,
  output logic [71:0]      O_R_DATA,
  input  logic             O_R_ACK,
  output logic [ERR_W-1:0] ERR_CNT
);

  localparam int unsigned CntW = $clog2(D_LEN + 1);
  localparam int unsigned SumW = ERR_W + 1;

  typedef enum logic [1:0] {StIdle, StDFwd, StRFwd, StDrop} state_e;
  typedef enum logic [1:0] {TgtDrop, TgtD, TgtR} tgt_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [SumW-1:0]   err_sum;
  tgt_e              tgt;
  logic              d_free, r_free;
  logic              acc_d, acc_r;
  logic              err_orphan, err_trunc, err_class;
  logic              d_stb_d, r_stb_d;

  assign ERR_CNT = err_q;

  // Word routing and input handshake: a header chooses its own target, any
  // other word follows the packet in progress.
  always_comb begin
    d_free = !O_D_STB | O_D_ACK;
    r_free = !O_R_STB | O_R_ACK;
    tgt    = TgtDrop;
    if (I_SOF) begin
      unique case (I_DATA[71:70])
        2'b00:   tgt = TgtD;
        2'b01:   tgt = TgtR;
        default: tgt = TgtDrop;
      endcase
    end else begin
      unique case (state_q)
        StDFwd:  tgt = TgtD;
        StRFwd:  tgt = TgtR;
        default: tgt = TgtDrop;
      endcase
    end
    unique case (tgt)
      TgtD:    I_ACK = I_STB & d_free;
      TgtR:    I_ACK = I_STB & r_free;
      default: I_ACK = I_STB;
    endcase
    acc_d = I_ACK & (tgt == TgtD);
    acc_r = I_ACK & (tgt == TgtR);
  end

  // Packet FSM next state, remaining-word counter and error accounting.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_orphan = 1'b0;
    err_trunc  = 1'b0;
    err_class  = 1'b0;
    if (I_ACK) begin
      if (I_SOF) begin
        // A header inside an unfinished packet truncates it.
        err_trunc = (state_q != StIdle);
        unique case (I_DATA[71:70])
          2'b00: begin
            state_d = StDFwd;
            cnt_d   = CntW'(D_LEN - 1);
          end
          2'b01: begin
            state_d = StRFwd;
            cnt_d   = CntW'(R_LEN - 1);
          end
          default: begin
            state_d   = StDrop;
            cnt_d     = CntW'(D_LEN - 1);
            err_class = 1'b1;
          end
        endcase
      end else if (state_q == StIdle) begin
        err_orphan = 1'b1;
      end else if (cnt_q == CntW'(1)) begin
        state_d = StIdle;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - CntW'(1);
      end
    end
    // Truncation and a bad-class header can land in the same cycle, so up to 2.
    err_sum = {1'b0, err_q} + SumW'(err_orphan) + SumW'(err_trunc) + SumW'(err_class);
    err_d   = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
    d_stb_d = acc_d | (O_D_STB & !O_D_ACK);
    r_stb_d = acc_r | (O_R_STB & !O_R_ACK);
  end

  // Control state and output valid/header flags.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      err_q   <= '0;
      O_D_STB <= 1'b0;
      O_R_STB <= 1'b0;
      O_D_SOF <= 1'b0;
      O_R_SOF <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      O_D_STB <= d_stb_d;
      O_R_STB <= r_stb_d;
      if (acc_d) O_D_SOF <= I_SOF;
      if (acc_r) O_R_SOF <= I_SOF;
    end
  end

  // Output data registers; qualified by STB so they need no reset.
  always_ff @(posedge CLK) begin
    if (acc_d) O_D_DATA <= I_DATA;
    if (acc_r) O_R_DATA <= I_DATA;
  end

endmodule

// File: tb/tb_sd_ring_demux.sv
// Self-checking bench for sd_ring_demux: directed scenarios plus random packet
// streams, compared cycle by cycle against a packet-level reference model.
module tb_sd_ring_demux;

  localparam int D_LEN = 9;
  localparam int R_LEN = 2;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        I_STB, I_SOF, I_ACK;
  logic [71:0] I_DATA;
  logic        O_D_STB, O_D_SOF, O_D_ACK;
  logic [71:0] O_D_DATA;
  logic        O_R_STB, O_R_SOF, O_R_ACK;
  logic [71:0] O_R_DATA;
  logic [7:0]  ERR_CNT;

  sd_ring_demux dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .I_STB    (I_STB),
    .I_SOF    (I_SOF),
    .I_DATA   (I_DATA),
    .I_ACK    (I_ACK),
    .O_D_STB  (O_D_STB),
    .O_D_SOF  (O_D_SOF),
    .O_D_DATA (O_D_DATA),
    .O_D_ACK  (O_D_ACK),
    .O_R_STB  (O_R_STB),
    .O_R_SOF  (O_R_SOF),
    .O_R_DATA (O_R_DATA),
    .O_R_ACK  (O_R_ACK),
    .ERR_CNT  (ERR_CNT)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: packet in progress (0 none, 1 data, 2 register, 3 drop),
  // words still owed by it, the word each output register should hold.
  int          mode, remain, m_err;
  bit          md_v, md_sof, mr_v, mr_sof;
  logic [71:0] md_w, mr_w;
  bit          last_acc;
  int          d_mode, r_mode, d_hold, r_hold;
  int          hs_d, hs_dsof, hs_r, hs_rsof, n_steps;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] rnd72();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[71:0];
  endfunction

  function automatic logic pick_ack(input int m);
    if (m == 2) return 1'($urandom_range(0, 1));
    return (m != 0);
  endfunction

  task automatic model_reset();
    mode = 0; remain = 0; m_err = 0;
    md_v = 0; mr_v = 0; md_sof = 0; mr_sof = 0;
  endtask

  // One clock: set consumer acks, check everything at the falling edge, then
  // advance the model across the rising edge.
  task automatic step();
    int tgt, inc;
    bit fd, fr, acc;
    if (d_hold > 0) begin O_D_ACK = 1'b0; d_hold--; end
    else O_D_ACK = pick_ack(d_mode);
    if (r_hold > 0) begin O_R_ACK = 1'b0; r_hold--; end
    else O_R_ACK = pick_ack(r_mode);
    @(negedge CLK);
    if (I_SOF) tgt = (I_DATA[71:70] == 2'b00) ? 1 : (I_DATA[71:70] == 2'b01) ? 2 : 0;
    else       tgt = (mode == 1) ? 1 : (mode == 2) ? 2 : 0;
    fd  = !md_v || O_D_ACK;
    fr  = !mr_v || O_R_ACK;
    acc = I_STB && (tgt == 0 || (tgt == 1 && fd) || (tgt == 2 && fr));
    chk("i_ack", I_ACK, acc);
    chk("d_stb", O_D_STB, md_v);
    chk("r_stb", O_R_STB, mr_v);
    if (md_v) begin
      chk("d_sof", O_D_SOF, md_sof);
      chk("d_data", O_D_DATA, md_w);
    end
    if (mr_v) begin
      chk("r_sof", O_R_SOF, mr_sof);
      chk("r_data", O_R_DATA, mr_w);
    end
    chk("err_cnt", ERR_CNT, 72'(m_err));
    if (O_D_STB === 1'b1 && O_D_ACK) begin hs_d++; if (O_D_SOF === 1'b1) hs_dsof++; end
    if (O_R_STB === 1'b1 && O_R_ACK) begin hs_r++; if (O_R_SOF === 1'b1) hs_rsof++; end
    @(posedge CLK);
    if (acc && tgt == 1) begin md_v = 1; md_w = I_DATA; md_sof = I_SOF; end
    else if (O_D_ACK) md_v = 0;
    if (acc && tgt == 2) begin mr_v = 1; mr_w = I_DATA; mr_sof = I_SOF; end
    else if (O_R_ACK) mr_v = 0;
    inc = 0;
    if (acc) begin
      if (I_SOF) begin
        if (mode != 0) inc++;
        unique case (tgt)
          1: begin mode = 1; remain = D_LEN - 1; end
          2: begin mode = 2; remain = R_LEN - 1; end
          default: begin mode = 3; remain = D_LEN - 1; inc++; end
        endcase
      end else if (mode == 0) begin
        inc++;
      end else begin
        remain--;
        if (remain == 0) mode = 0;
      end
    end
    m_err = (m_err + inc > 255) ? 255 : m_err + inc;
    last_acc = acc;
    n_steps++;
    #1;
  endtask

  task automatic send_word(input bit sof, input logic [71:0] w);
    int n = 0;
    I_STB = 1'b1; I_SOF = sof; I_DATA = w;
    do begin step(); n++; end while (!last_acc && n < 64);
    if (!last_acc) begin
      n_cmp++; n_fail++;
      $display("FAIL send_word timeout got no I_ACK expected accept within 64 cycles");
    end
  endtask

  task automatic send_hdr(input logic [1:0] cls);
    logic [71:0] w;
    w = rnd72();
    w[71:70] = cls;
    send_word(1'b1, w);
  endtask

  task automatic send_body(input int n);
    for (int i = 0; i < n; i++) send_word(1'b0, rnd72());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      I_STB = 1'b0; I_SOF = 1'($urandom_range(0, 1)); I_DATA = rnd72();
      step();
    end
  endtask

  task automatic clr_hs();
    hs_d = 0; hs_dsof = 0; hs_r = 0; hs_rsof = 0; n_steps = 0;
  endtask

  // Reset applied asynchronously between edges; outputs must drop at once.
  task automatic do_reset();
    RST_N = 1'b0; I_STB = 1'b0; I_SOF = 1'b0;
    #1;
    model_reset();
    chk("rst_d_stb", O_D_STB, 1'b0);
    chk("rst_r_stb", O_R_STB, 1'b0);
    chk("rst_err", ERR_CNT, 72'(0));
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    clr_hs();
  endtask

  initial begin
    RST_N = 1'b1; I_STB = 0; I_SOF = 0; I_DATA = '0; O_D_ACK = 0; O_R_ACK = 0;
    d_mode = 1; r_mode = 1; d_hold = 0; r_hold = 0;
    model_reset();
    #2;
    do_reset();

    // Data packet, consumer always ready.
    send_hdr(2'b00); send_body(D_LEN - 1); idle(3);
    chk("t1_d_words", 72'(hs_d), 72'(9));
    chk("t1_d_sofs", 72'(hs_dsof), 72'(1));
    chk("t1_r_words", 72'(hs_r), 72'(0));
    chk("t1_err", ERR_CNT, 72'(0));

    // Register packet with the register consumer stalled 3 cycles.
    clr_hs();
    r_hold = 3;
    send_hdr(2'b01); send_body(R_LEN - 1); idle(3);
    chk("t2_r_words", 72'(hs_r), 72'(2));
    chk("t2_r_sofs", 72'(hs_rsof), 72'(1));

    // Data then register back-to-back, register consumer stalled meanwhile.
    clr_hs();
    r_hold = 14;
    send_hdr(2'b00); send_body(D_LEN - 1);
    send_hdr(2'b01); send_body(R_LEN - 1); idle(3);
    chk("t3_d_words", 72'(hs_d), 72'(9));
    chk("t3_r_words", 72'(hs_r), 72'(2));

    // Unknown class: swallowed whole.
    do_reset();
    send_hdr(2'b10); send_body(D_LEN - 1);
    chk("t4_steps", 72'(n_steps), 72'(9));
    idle(2);
    chk("t4_outs", 72'(hs_d + hs_r), 72'(0));
    chk("t4_err", ERR_CNT, 72'(1));

    // Data packet truncated by a register header, repeated to saturation.
    do_reset();
    for (int k = 0; k < 300; k++) begin
      send_hdr(2'b00); send_body(3);
      send_hdr(2'b01); send_body(R_LEN - 1);
      if (k == 0) begin
        idle(2);
        chk("t5_d_words", 72'(hs_d), 72'(4));
        chk("t5_r_words", 72'(hs_r), 72'(2));
        chk("t5_err1", ERR_CNT, 72'(1));
      end
    end
    idle(2);
    chk("t5_err_sat", ERR_CNT, 72'(255));

    // Reset mid data packet; the tail arrives headerless.
    do_reset();
    send_hdr(2'b00); send_body(3);
    do_reset();
    send_body(5); idle(2);
    chk("t6_outs", 72'(hs_d + hs_r), 72'(0));
    chk("t6_err", ERR_CNT, 72'(5));

    // Random packet streams with random consumer backpressure.
    do_reset();
    d_mode = 2; r_mode = 2;
    for (int p = 0; p < 200; p++) begin
      int cls, len;
      if ($urandom_range(0, 9) == 0) send_body(1);
      cls = $urandom_range(0, 3);
      len = (cls == 1) ? R_LEN : D_LEN;
      if ($urandom_range(0, 4) == 0) len = $urandom_range(1, len - 1);
      send_hdr(2'(cls));
      send_body(len - 1);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    d_mode = 1; r_mode = 1;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
